// File: rtl/theta_pkg.sv
// Shared definitions for the theta sweep controller: Q2.32 widths, index width,
// FSM state encoding and the table-size helper.
package theta_pkg;

  localparam int unsigned Q_WIDTH    = 34;
  localparam int unsigned Q_FRAC     = 32;
  localparam int unsigned IDX_WIDTH  = 12;
  localparam int unsigned MAX_POINTS = 1 << IDX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_STORE_M,
    S_DONE,
    S_ERR
  } sweepState_t;

  function automatic int unsigned totalPoints(input int unsigned frameColumns,
                                              input int unsigned frameNumber);
    return frameColumns * frameNumber;
  endfunction

endpackage

// File: rtl/sweep_timeout.sv
// Clearable saturating cycle counter; tc flags that TIMEOUT_P-1 cycles have
// elapsed since the last clear.
module sweep_timeout #(
  parameter int unsigned TIMEOUT_P = 1024
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic clr,
  output logic tc
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_P + 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(TIMEOUT_P - 1));

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/theta_sweep_ctrl.sv
// Sweeps iteration indices through the theta-cosine stage and writes each
// result into the position table. Optional macro: THETA_SWEEP_SYMM_EN.
module theta_sweep_ctrl
  import theta_pkg::*;
#(
  parameter int unsigned FRAME_COLUMNS_P = 360,
  parameter int unsigned FRAME_NUMBER_P  = 5,
  parameter int unsigned TIMEOUT_P       = 1024
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic                 start_i,
  output logic                 theta_iteration_valid_o,
  output logic [11:0]          theta_iteration_o,
  input  logic                 thetaCos_valid_i,
  input  logic [33:0]          thetaCos_i,
  output logic                 wr_en_o,
  output logic [11:0]          wr_addr_o,
  output logic [33:0]          wr_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int unsigned TOTAL_POINTS_P = totalPoints(FRAME_COLUMNS_P, FRAME_NUMBER_P);

  if (TOTAL_POINTS_P == 0 || TOTAL_POINTS_P > MAX_POINTS) begin : gBadSize
    $error("theta_sweep_ctrl: TOTAL_POINTS_P out of range");
  end

`ifdef THETA_SWEEP_SYMM_EN
  localparam int unsigned LAST_I = (TOTAL_POINTS_P + 1) / 2 - 1;
`else
  localparam int unsigned LAST_I = TOTAL_POINTS_P - 1;
`endif
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LAST_I);

  sweepState_t          state;
  logic [IDX_WIDTH-1:0] index;
  logic                 validQ;
  logic                 resultRise;
  logic                 tmoClr;
  logic                 tmoHit;

`ifdef THETA_SWEEP_SYMM_EN
  localparam logic [IDX_WIDTH-1:0] TOP_IDX = IDX_WIDTH'(TOTAL_POINTS_P - 1);
  logic [IDX_WIDTH-1:0] mirrorIdx;
  assign mirrorIdx = TOP_IDX - index;
`endif

  assign theta_iteration_o = index;
  assign resultRise        = thetaCos_valid_i & ~validQ;

  // Cleared on the edge that enters ISSUE so the count equals cycles since the request.
  assign tmoClr = !((state == S_ISSUE) || (state == S_WAIT));

  sweep_timeout #(
    .TIMEOUT_P(TIMEOUT_P)
  ) uTimeout (
    .clk_i (clk_i),
    .nrst_i(nrst_i),
    .clr   (tmoClr),
    .tc    (tmoHit)
  );

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state                   <= S_IDLE;
      index                   <= '0;
      validQ                  <= 1'b0;
      theta_iteration_valid_o <= 1'b0;
      wr_en_o                 <= 1'b0;
      wr_addr_o               <= '0;
      wr_data_o               <= '0;
      busy_o                  <= 1'b0;
      done_o                  <= 1'b0;
      error_o                 <= 1'b0;
    end else begin
      validQ                  <= thetaCos_valid_i;
      theta_iteration_valid_o <= 1'b0;
      wr_en_o                 <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            index                   <= '0;
            done_o                  <= 1'b0;
            error_o                 <= 1'b0;
            busy_o                  <= 1'b1;
            theta_iteration_valid_o <= 1'b1;
            state                   <= S_ISSUE;
          end
        end

        S_ISSUE: state <= S_WAIT;

        S_WAIT: begin
          if (resultRise) begin
            // wr_data_o doubles as the latch for the accepted result.
            wr_en_o   <= 1'b1;
            wr_addr_o <= index;
            wr_data_o <= thetaCos_i;
            state     <= S_STORE;
          end else if (tmoHit) begin
            error_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= S_ERR;
          end
        end

        S_STORE: begin
`ifdef THETA_SWEEP_SYMM_EN
          if (index != mirrorIdx) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= mirrorIdx;
            wr_data_o <= -wr_data_o;
            state     <= S_STORE_M;
          end else
`endif
          if (index == LAST_IDX) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else begin
            index                   <= index + 1'b1;
            theta_iteration_valid_o <= 1'b1;
            state                   <= S_ISSUE;
          end
        end

`ifdef THETA_SWEEP_SYMM_EN
        S_STORE_M: begin
          if (index == LAST_IDX) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else begin
            index                   <= index + 1'b1;
            theta_iteration_valid_o <= 1'b1;
            state                   <= S_ISSUE;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_theta_sweep_ctrl.sv
// Directed and randomized bench for theta_sweep_ctrl with an in-bench cosine
// stub and a table-write reference model (N=4, TIMEOUT_P=16).
module tb_theta_sweep_ctrl;

  localparam int N       = 4;
  localparam int TMO     = 16;
`ifdef THETA_SWEEP_SYMM_EN
  localparam int NUM_REQ = (N + 1) / 2;
`else
  localparam int NUM_REQ = N;
`endif

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        theta_iteration_valid_o;
  logic [11:0] theta_iteration_o;
  logic        thetaCos_valid_i = 1'b0;
  logic [33:0] thetaCos_i = '0;
  logic        wr_en_o;
  logic [11:0] wr_addr_o;
  logic [33:0] wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  theta_sweep_ctrl #(
    .FRAME_COLUMNS_P(N),
    .FRAME_NUMBER_P (1),
    .TIMEOUT_P      (TMO)
  ) dut (
    .clk_i                  (clk_i),
    .nrst_i                 (nrst_i),
    .start_i                (start_i),
    .theta_iteration_valid_o(theta_iteration_valid_o),
    .theta_iteration_o      (theta_iteration_o),
    .thetaCos_valid_i       (thetaCos_valid_i),
    .thetaCos_i             (thetaCos_i),
    .wr_en_o                (wr_en_o),
    .wr_addr_o              (wr_addr_o),
    .wr_data_o              (wr_data_o),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .error_o                (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [11:0] a;
    logic [33:0] d;
  } wr_t;

  wr_t         expQ[$];
  int          passCnt = 0;
  int          failCnt = 0;
  int          totalCnt = 0;
  int          extraWrites = 0;
  logic [33:0] patt [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any table write against the model.
  task automatic tick();
    wr_t e;
    @(negedge clk_i);
    if (wr_en_o === 1'b1) begin
      if (expQ.size() == 0) begin
        extraWrites++;
        chk("wr_unexpected", {52'd0, wr_addr_o}, 64'hFFF);
      end else begin
        e = expQ.pop_front();
        chk("wr_addr", {52'd0, wr_addr_o}, {52'd0, e.a});
        chk("wr_data", {30'd0, wr_data_o}, {30'd0, e.d});
      end
    end
  endtask

  task automatic waitReq(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      if (theta_iteration_valid_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic runSweep(input int latArg, input bit stale, input bit poke,
                          input bit rnd, input int abortAt);
    logic [33:0] resp [N];
    int          lat;
    bit          seen;
    wr_t         w;
    for (int i = 0; i < N; i++)
      resp[i] = rnd ? {2'($urandom_range(3, 0)), $urandom()} : patt[i];
    expQ.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      w.a = 12'(i); w.d = resp[i]; expQ.push_back(w);
`ifdef THETA_SWEEP_SYMM_EN
      if (N - 1 - i != i) begin
        w.a = 12'(N - 1 - i); w.d = 34'(0) - resp[i]; expQ.push_back(w);
      end
`endif
    end
    thetaCos_valid_i = stale;
    thetaCos_i       = {2'($urandom_range(3, 0)), $urandom()};
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("req_after_start", {63'd0, theta_iteration_valid_o}, 64'd1);
    chk("err_cleared", {63'd0, error_o}, 64'd0);
    chk("done_cleared", {63'd0, done_o}, 64'd0);
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r > 0) begin
        waitReq(seen);
        chk("req_seen", {63'd0, seen}, 64'd1);
      end
      chk("req_idx", {52'd0, theta_iteration_o}, 64'(r));
      chk("busy", {63'd0, busy_o}, 64'd1);
      if (r == abortAt) begin
        tick();
        nrst_i = 1'b0;
        #1;
        chk("abort_zero", {1'b0, theta_iteration_valid_o, theta_iteration_o, wr_en_o, wr_addr_o,
                           wr_data_o, busy_o, done_o, error_o}, 64'd0);
        thetaCos_valid_i = 1'b0;
        @(negedge clk_i);
        nrst_i = 1'b1;
        expQ.delete();
        return;
      end
      lat = (latArg > 0) ? latArg : int'($urandom_range(10, 1));
      for (int k = 0; k < lat; k++) begin
        if (poke && r == 1 && k == 0) start_i = 1'b1;
        tick();
        start_i = 1'b0;
      end
      if (stale) begin
        thetaCos_valid_i = 1'b0;
        tick();
      end
      thetaCos_valid_i = 1'b1;
      thetaCos_i       = resp[r];
      tick();
      chk("wr_strobe", {63'd0, wr_en_o}, 64'd1);
      chk("idx_hold", {52'd0, theta_iteration_o}, 64'(r));
      if (!stale) thetaCos_valid_i = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick();
      if (done_o === 1'b1) seen = 1'b1;
    end
    chk("done", {63'd0, done_o}, 64'd1);
    chk("idle_busy", {63'd0, busy_o}, 64'd0);
    chk("idle_err", {63'd0, error_o}, 64'd0);
    chk("all_written", 64'(expQ.size()), 64'd0);
    thetaCos_valid_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit seen;
    patt[0] = 34'h1_0000_0000;
    patt[1] = 34'h0_5555_5555;
    patt[2] = 34'h3_AAAA_AAAB;
    patt[3] = 34'h3_0000_0000;

    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {1'b0, theta_iteration_valid_o, theta_iteration_o, wr_en_o, wr_addr_o,
                          wr_data_o, busy_o, done_o, error_o}, 64'd0);
    nrst_i = 1'b1;
    tick();
    tick();
    chk("idle_after_reset", {61'd0, busy_o, done_o, error_o}, 64'd0);

    // Known cosine pattern with fixed latency 5.
    runSweep(5, 1'b0, 1'b0, 1'b0, -1);

    // Result-valid level held high across requests.
    runSweep(0, 1'b1, 1'b0, 1'b1, -1);

    // Silent stub: timeout exactly TMO cycles after the request.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("tmo_req", {63'd0, theta_iteration_valid_o}, 64'd1);
    for (int k = 0; k < TMO - 1; k++) tick();
    chk("tmo_not_early", {62'd0, error_o, busy_o}, 64'd1);
    tick();
    chk("tmo_error", {63'd0, error_o}, 64'd1);
    chk("tmo_busy", {63'd0, busy_o}, 64'd0);
    tick();
    chk("tmo_no_writes", 64'(extraWrites), 64'd0);
    runSweep(0, 1'b0, 1'b0, 1'b1, -1);

    // start_i while busy must not disturb the index sequence.
    runSweep(0, 1'b0, 1'b1, 1'b1, -1);

    // Reset mid-sweep, then a clean sweep from index 0.
    runSweep(3, 1'b0, 1'b0, 1'b1, (NUM_REQ > 2) ? 2 : NUM_REQ - 1);
    tick();
    chk("post_abort_done", {62'd0, done_o, busy_o}, 64'd0);
    runSweep(0, 1'b0, 1'b0, 1'b1, -1);

    for (int s = 0; s < 3; s++) runSweep(0, s[0], 1'b0, 1'b1, -1);

    // start_i in DONE restarts cleanly; confirm no stray writes once idle.
    chk("no_extra_writes", 64'(extraWrites), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/theta_sweep_ctrl.md
# theta_sweep_ctrl

Sweep controller that sits directly upstream of the theta-cosine stage. It drives the iteration index 0..TOTAL_POINTS_P-1 into that stage one request at a time and captures each normalized cosine result. It writes each result into an external position table through a simple write port. It reports busy/done/error so the timing core can start scanning only after the table is complete.

## Interface
- FRAME_COLUMNS_P, 360, columns per frame
- FRAME_NUMBER_P, 5, frames per mirror half-period
- TIMEOUT_P, 1024, max cycles to wait for one result before error
- TOTAL_POINTS_P (localparam), FRAME_COLUMNS_P*FRAME_NUMBER_P; must be ≤ 4096
- clk_i  in  1  clock
- nrst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle pulse; begins a sweep when idle
- theta_iteration_valid_o  out  1  one-cycle request pulse to the cosine stage
- theta_iteration_o  out  12  iteration index, held stable from request until the result is accepted
- thetaCos_valid_i  in  1  result valid from the cosine stage (level; may stay high)
- thetaCos_i  in  34  signed Q2.32 result
- wr_en_o  out  1  table write strobe
- wr_addr_o  out  12  table address
- wr_data_o  out  34  table data (Q2.32)
- busy_o  out  1  sweep in progress
- done_o  out  1  sticky; table complete; cleared by the next start_i
- error_o  out  1  sticky; timeout occurred; cleared by the next start_i

## Operation
- States: IDLE, ISSUE, WAIT, STORE, STORE_M (only with macro), DONE, ERR.
- IDLE: on start_i, clear the index, done_o and error_o, then go to ISSUE. start_i in any other state except DONE or ERR is ignored.
- ISSUE: drive theta_iteration_valid_o=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
- WAIT: a result is accepted only on a rising edge of thetaCos_valid_i, detected by a registered copy of the input. Stale high levels are never accepted.
  - On acceptance, latch thetaCos_i and go to STORE.
  - If the counter reaches TIMEOUT_P-1 with no edge, go to ERR.
- STORE: wr_en_o=1, wr_addr_o=index, wr_data_o=latched value.
  - If index == last, go to DONE.
  - Otherwise increment the index and go to ISSUE.
- DONE: done_o=1, busy_o=0. start_i restarts the sweep (same as IDLE).
- ERR: error_o=1, busy_o=0, no writes. start_i restarts the sweep.
- busy_o=1 in ISSUE, WAIT, STORE and STORE_M.
- Only one request is outstanding at any time.
- Reset mid-sweep: return immediately to IDLE. Partial table contents are undefined, and done_o stays 0.
- Reset values: all outputs 0; index 0; state IDLE.

## Timing
- The request pulse occurs the cycle after start_i, and the cycle after each STORE.
- Acceptance edge at cycle t gives wr_en_o at t+1.
- Per-point cost is 3 cycles plus the downstream latency L. A full sweep takes N·(3+L) cycles, plus one extra cycle per point with the macro.
- theta_iteration_o stays constant from ISSUE through STORE.

## Configuration
- THETA_SWEEP_SYMM_EN defined: the controller uses cos-position symmetry, value(N-1-i) = -value(i).
  - Last index becomes ceil(N/2)-1.
  - After STORE, STORE_M writes address N-1-i with the 34-bit two's-complement negation of the result.
  - For odd N, the middle point (i == N-1-i) skips STORE_M.
  - Sweep time is roughly halved.
- Not defined: all N indices are issued and there is no STORE_M state.

## Structure
- Shared package theta_pkg holds:
  - the Q2.32 width constants (34 total, 32 fractional)
  - the 12-bit index width
  - the state enum encoding
  - a TOTAL_POINTS helper function
- One sub-module, sweep_timeout: a clearable counter with a TIMEOUT_P terminal-count flag. Everything else lives in a single FSM module.

## Test plan
- Normal sweep, FRAME_COLUMNS_P=4, FRAME_NUMBER_P=1, stub with L=5 returning Q2.32 (3-2i)/3:
  - 4 writes, addr 0..3
  - data 34'h1_0000_0000, 34'h0_5555_5555, 34'h3_AAAA_AAAB, 34'h3_0000_0000
  - done_o=1 after the last write
- Stale level: stub holds thetaCos_valid_i high across ISSUE → no acceptance until it falls and rises again, and each address is written exactly once.
- Timeout, TIMEOUT_P=16: stub never responds → error_o=1 exactly 16 cycles after the request, no wr_en_o, busy_o=0. A following start_i clears error_o and reissues index 0.
- Reset mid-sweep at index 2 → all outputs 0 in the same cycle. A new start_i reissues index 0.
- With THETA_SWEEP_SYMM_EN, N=4: only indices 0 and 1 are requested. Writes are addr0=1.0, addr3=-1.0, addr1=0x0_5555_5555, addr2=0x3_AAAA_AAAB. With N=5, index 2 is written once.
- start_i while busy → ignored, and the index sequence is unchanged.
